// File: rtl/float_to_int_serial_if.sv
// float_to_int_serial_if
//   Bundles the two valid/ready streams of the serial float-to-int converter.
//   Input stream : s_valid, s_ready, s_data = {sign, exponent, mantissa}
//   Output stream: m_valid, m_ready, m_data (signed integer), m_overflow
//   Modports:
//     slave  - the converter (consumes floats, produces integers)
//     master - the environment (produces floats, consumes integers)
interface float_to_int_serial_if #(
  parameter int EXPONENT_SIZE = 8,
  parameter int MANTISSA_SIZE = 23,
  parameter int INT_SIZE      = 32
);
  logic                                 s_valid;
  logic                                 s_ready;
  logic [EXPONENT_SIZE+MANTISSA_SIZE:0] s_data;
  logic                                 m_valid;
  logic                                 m_ready;
  logic [INT_SIZE-1:0]                  m_data;
  logic                                 m_overflow;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_overflow
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_overflow
  );
endinterface

// File: rtl/float_to_int_serial.sv
// float_to_int_serial
//   Serial float to saturated two's-complement integer converter. The
//   hidden-bit mantissa is shifted one position per cycle until the binary
//   point is aligned, then the sign is applied.
//   Ports:
//     clk    - clock, all state on the rising edge
//     resetn - asynchronous active-low reset
//     bus    - float_to_int_serial_if.slave (s_* float in, m_* integer out)
//   Optional feature (macro FLOAT_TO_INT_ROUND_EN): round to nearest, ties to
//   even, using guard/sticky bits on the right-shift path. When undefined the
//   magnitude truncates toward zero.
module float_to_int_serial #(
  parameter int EXPONENT_SIZE = 8,
  parameter int MANTISSA_SIZE = 23,
  parameter int INT_SIZE      = 32
) (
  input logic                  clk,
  input logic                  resetn,
  float_to_int_serial_if.slave bus
);

  localparam int BIAS  = (1 << (EXPONENT_SIZE - 1)) - 1;
  localparam int CNT_W = $clog2(INT_SIZE + MANTISSA_SIZE + 2);
`ifdef FLOAT_TO_INT_ROUND_EN
  // e == -1 can still round up to 1, so it takes the shift path.
  localparam int MIN_E = -1;
`else
  localparam int MIN_E = 0;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, OUT} state_t;

  function automatic logic [INT_SIZE-1:0] saturate(input logic neg);
    return neg ? {1'b1, {(INT_SIZE-1){1'b0}}} : {1'b0, {(INT_SIZE-1){1'b1}}};
  endfunction

  function automatic logic [INT_SIZE-1:0] apply_sign(input logic neg,
                                                     input logic [INT_SIZE-1:0] mag);
    return neg ? -mag : mag;
  endfunction

`ifdef FLOAT_TO_INT_ROUND_EN
  function automatic logic [INT_SIZE-1:0] round_rne(input logic [INT_SIZE-1:0] mag,
                                                    input logic guard_bit,
                                                    input logic sticky_bit);
    return mag + INT_SIZE'(guard_bit & (sticky_bit | mag[0]));
  endfunction
`endif

  state_t                  state;
  logic [INT_SIZE-1:0]     acc;
  logic [CNT_W-1:0]        count;
  logic                    dir_left;
  logic                    sign_r;
  // Special results are loaded into m_data at acceptance and only released
  // after one pass through SHIFT, so every result leaves on a registered edge.
  logic                    special;
`ifdef FLOAT_TO_INT_ROUND_EN
  logic                    guard;
  logic                    sticky;
`endif

  logic                     sign_in;
  logic [EXPONENT_SIZE-1:0] exp_in;
  logic [MANTISSA_SIZE-1:0] mant_in;
  int                       e_in;
  logic [INT_SIZE-1:0]      mag_final;

  assign sign_in = bus.s_data[EXPONENT_SIZE+MANTISSA_SIZE];
  assign exp_in  = bus.s_data[EXPONENT_SIZE+MANTISSA_SIZE-1 -: EXPONENT_SIZE];
  assign mant_in = bus.s_data[MANTISSA_SIZE-1:0];
  assign e_in    = int'(exp_in) - BIAS;

  assign bus.s_ready = (state == IDLE);

`ifdef FLOAT_TO_INT_ROUND_EN
  assign mag_final = round_rne(acc, guard, sticky);
`else
  assign mag_final = acc;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      acc            <= '0;
      count          <= '0;
      dir_left       <= 1'b0;
      sign_r         <= 1'b0;
      special        <= 1'b0;
`ifdef FLOAT_TO_INT_ROUND_EN
      guard          <= 1'b0;
      sticky         <= 1'b0;
`endif
      bus.m_valid    <= 1'b0;
      bus.m_data     <= '0;
      bus.m_overflow <= 1'b0;
    end else begin
      case (state)
        // Accept and classify the incoming float.
        IDLE: begin
          if (bus.s_valid) begin
            sign_r         <= sign_in;
            acc            <= INT_SIZE'({1'b1, mant_in});
            count          <= '0;
            dir_left       <= 1'b0;
            special        <= 1'b1;
`ifdef FLOAT_TO_INT_ROUND_EN
            guard          <= 1'b0;
            sticky         <= 1'b0;
`endif
            bus.m_data     <= '0;
            bus.m_overflow <= 1'b0;
            state          <= SHIFT;
            if (exp_in == '0) begin
              bus.m_data <= '0;
            end else if (exp_in == '1) begin
              bus.m_data     <= (mant_in != '0) ? saturate(1'b0) : saturate(sign_in);
              bus.m_overflow <= 1'b1;
            end else if (e_in >= INT_SIZE - 1) begin
              bus.m_data     <= saturate(sign_in);
              // -2^(INT_SIZE-1) itself is representable.
              bus.m_overflow <= !(sign_in && (e_in == INT_SIZE - 1) && (mant_in == '0));
            end else if (e_in < MIN_E) begin
              bus.m_data <= '0;
            end else begin
              special  <= 1'b0;
              dir_left <= (e_in >= MANTISSA_SIZE);
              count    <= CNT_W'((e_in >= MANTISSA_SIZE) ? (e_in - MANTISSA_SIZE)
                                                          : (MANTISSA_SIZE - e_in));
            end
          end
        end
        // One bit of alignment per cycle, then sign the magnitude.
        SHIFT: begin
          if (count != '0) begin
            count <= count - CNT_W'(1);
            if (dir_left) begin
              acc <= acc << 1;
            end else begin
              acc <= acc >> 1;
`ifdef FLOAT_TO_INT_ROUND_EN
              guard  <= acc[0];
              sticky <= sticky | guard;
`endif
            end
          end else begin
            if (!special) begin
              bus.m_data     <= apply_sign(sign_r, mag_final);
              bus.m_overflow <= 1'b0;
            end
            bus.m_valid <= 1'b1;
            state       <= OUT;
          end
        end
        // Hold the result until the consumer takes it.
        OUT: begin
          if (bus.m_ready) begin
            bus.m_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_to_int_serial.sv
module tb_float_to_int_serial;

  logic clk;
  logic resetn;

  float_to_int_serial_if #(.EXPONENT_SIZE(8), .MANTISSA_SIZE(23), .INT_SIZE(32)) bus ();

  float_to_int_serial #(.EXPONENT_SIZE(8), .MANTISSA_SIZE(23), .INT_SIZE(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] din;
    logic [31:0] q_trunc;
    logic [31:0] q_round;
    logic        ovf;
    int          lat_trunc;
    int          lat_round;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        ovf;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Present a float and wait (bounded) for the acceptance edge; returns after it.
  task automatic accept_one(input logic [31:0] din, output logic ok);
    int waited;
    @(negedge clk);
    bus.s_data  = din;
    bus.s_valid = 1'b1;
    waited = 0;
    while (!bus.s_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    ok = bus.s_ready;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept: s_ready never rose for %h", din);
    end
    @(posedge clk);
    @(negedge clk);
    bus.s_valid = 1'b0;
    // s_data is only sampled at acceptance.
    bus.s_data  = $urandom;
  endtask

  task automatic convert(input string name, input logic [31:0] din,
                         input logic [31:0] edata, input logic eovf,
                         input int elat, input int hold);
    exp_t e;
    exp_t got;
    logic ok;
    int   lat;
    e.data = edata;
    e.ovf  = eovf;
    e.lat  = elat;
    sb.push_back(e);
    accept_one(din, ok);
    if (!ok) begin
      void'(sb.pop_front());
      return;
    end
    // Already past the acceptance edge and at the following negedge.
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.m_valid) break;
    end
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: output with empty scoreboard", name);
      return;
    end
    got = sb.pop_front();
    if (!bus.m_valid) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: m_valid never rose, expected after %0d cycles", name, got.lat);
      return;
    end
    chk({name, " data"}, bus.m_data, got.data);
    chk({name, " ovf"}, {31'd0, bus.m_overflow}, {31'd0, got.ovf});
    chk({name, " latency"}, lat, got.lat);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({name, " hold"}, {bus.m_valid, bus.s_ready, bus.m_overflow, bus.m_data[28:0]},
          {1'b1, 1'b0, got.ovf, got.data[28:0]});
      chk({name, " hold data"}, bus.m_data, got.data);
    end
    @(negedge clk);
    bus.m_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({name, " after handshake"}, {30'd0, bus.s_ready, bus.m_valid}, {30'd0, 1'b1, 1'b0});
    @(negedge clk);
    bus.m_ready = 1'b0;
  endtask

  vec_t vecs[22];

  initial begin
    logic ok;
    int   stale;

    vecs[0]  = '{32'h3F800000, 32'h00000001, 32'h00000001, 1'b0, 24, 24}; // 1.0
    vecs[1]  = '{32'h00000000, 32'h00000000, 32'h00000000, 1'b0,  1,  1}; // 0
    vecs[2]  = '{32'hC0200000, 32'hFFFFFFFE, 32'hFFFFFFFE, 1'b0, 23, 23}; // -2.5
    vecs[3]  = '{32'h40600000, 32'h00000003, 32'h00000004, 1'b0, 23, 23}; // 3.5
    vecs[4]  = '{32'h4F000000, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1,  1,  1}; // 2^31
    vecs[5]  = '{32'hCF000000, 32'h80000000, 32'h80000000, 1'b0,  1,  1}; // -2^31
    vecs[6]  = '{32'h7FC00000, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1,  1,  1}; // NaN
    vecs[7]  = '{32'h3F000000, 32'h00000000, 32'h00000000, 1'b0,  1, 25}; // 0.5
    vecs[8]  = '{32'h3F400000, 32'h00000000, 32'h00000001, 1'b0,  1, 25}; // 0.75
    vecs[9]  = '{32'h4E800000, 32'h40000000, 32'h40000000, 1'b0,  8,  8}; // 2^30
    vecs[10] = '{32'hFF800000, 32'h80000000, 32'h80000000, 1'b1,  1,  1}; // -Inf
    vecs[11] = '{32'h7F800000, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1,  1,  1}; // +Inf
    vecs[12] = '{32'h4B000001, 32'h00800001, 32'h00800001, 1'b0,  1,  1}; // 2^23+1
    vecs[13] = '{32'hCB7FFFFF, 32'hFF000001, 32'hFF000001, 1'b0,  1,  1}; // -(2^24-1)
    vecs[14] = '{32'h00400000, 32'h00000000, 32'h00000000, 1'b0,  1,  1}; // subnormal
    vecs[15] = '{32'hCF000001, 32'h80000000, 32'h80000000, 1'b1,  1,  1}; // < -2^31
    vecs[16] = '{32'h4EFFFFFF, 32'h7FFFFF80, 32'h7FFFFF80, 1'b0,  8,  8}; // max < 2^31
    vecs[17] = '{32'hBFC00000, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 24, 24}; // -1.5
    vecs[18] = '{32'h3FC00000, 32'h00000001, 32'h00000002, 1'b0, 24, 24}; // 1.5
    vecs[19] = '{32'h40A00000, 32'h00000005, 32'h00000005, 1'b0, 22, 22}; // 5.0
    vecs[20] = '{32'h3EFFFFFF, 32'h00000000, 32'h00000000, 1'b0,  1,  1}; // < 0.5
    vecs[21] = '{32'hBF7FFFFF, 32'h00000000, 32'hFFFFFFFF, 1'b0,  1, 25}; // ~-1

    resetn      = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset m_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("reset m_data", bus.m_data, 32'd0);
    chk("reset m_overflow", {31'd0, bus.m_overflow}, 32'd0);
    chk("reset s_ready", {31'd0, bus.s_ready}, 32'd1);
    resetn = 1'b1;

    for (int i = 0; i < 22; i++) begin
`ifdef FLOAT_TO_INT_ROUND_EN
      convert($sformatf("vec%0d", i), vecs[i].din, vecs[i].q_round, vecs[i].ovf,
              vecs[i].lat_round, i % 3);
`else
      convert($sformatf("vec%0d", i), vecs[i].din, vecs[i].q_trunc, vecs[i].ovf,
              vecs[i].lat_trunc, i % 3);
`endif
    end

    // Long back-pressure, then a back-to-back conversion.
    convert("backpressure", 32'h3F800000, 32'h00000001, 1'b0, 24, 10);
    convert("after_bp", 32'h40A00000, 32'h00000005, 1'b0, 22, 0);

    // Asynchronous reset while a saturated result is held in OUT.
    accept_one(32'hFF800000, ok);
    @(negedge clk);
    chk("pre-reset out", {bus.m_valid, bus.m_overflow, bus.m_data[29:0]},
        {1'b1, 1'b1, 30'd0});
    #2 resetn = 1'b0;
    #1;
    chk("reset in OUT", {bus.m_valid, bus.m_overflow, bus.m_data[29:0]}, 32'd0);
    chk("reset in OUT data", bus.m_data, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Asynchronous reset mid-SHIFT: the conversion must vanish.
    accept_one(32'h3F800000, ok);
    repeat (5) @(negedge clk);
    chk("mid-shift s_ready", {31'd0, bus.s_ready}, 32'd0);
    #2 resetn = 1'b0;
    #1;
    chk("reset in SHIFT", {bus.m_valid, bus.m_overflow, bus.m_data[29:0]}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("s_ready after reset", {31'd0, bus.s_ready}, 32'd1);
    stale = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.m_valid) stale++;
    end
    chk("no stale result", stale, 0);
    convert("post_reset", 32'hC0200000, 32'hFFFFFFFE, 1'b0, 23, 1);

    chk("scoreboard empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
